// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory arbiter.
// Imported by arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int LAT_CNT_W   = 4;

    // Out-of-range latencies are clamped so the counter load always fits.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int mem_lat);
        int clamped;
        clamped = mem_lat;
        if (clamped < MEM_LAT_MIN) clamped = MEM_LAT_MIN;
        if (clamped > MEM_LAT_MAX) clamped = MEM_LAT_MAX;
        return LAT_CNT_W'(clamped - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Tie-break for the two requesters: a tie goes to the side opposite last_grant.
// Pure combinational; the winner is only meaningful while a request is pending.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output req_id_t winner
);

    always_comb begin
        winner = REQ_D;
        if (i_req && d_req) begin
            winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (i_req) begin
            winner = REQ_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with fixed latency MEM_LAT.
// Define ARB_ROUND_ROBIN_EN to alternate ties; otherwise data always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_we,
    input  logic [31:0] m_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    arb_state_t           state_q;
    req_id_t              winner_q;
    req_id_t              winner_d;
    req_id_t              last_grant;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           we_q;
    logic [31:0]          i_rdata_q;
    logic [31:0]          d_rdata_q;
    logic                 i_valid_q;
    logic                 d_valid_q;
    logic                 any_req;
    logic                 arb_open;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_grant_q;
    assign last_grant = last_grant_q;
`else
    // Pretending the fetch side won last makes every tie go to data.
    assign last_grant = REQ_I;
`endif

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .winner     (winner_d)
    );

    assign any_req  = i_req | d_req;
    // Grants must fall in the arbitration cycle itself, so they are decoded, not registered.
    assign arb_open = (state_q == ST_IDLE) && !reset && any_req;
    assign i_gnt    = arb_open && (winner_d == REQ_I);
    assign d_gnt    = arb_open && (winner_d == REQ_D);

    assign i_valid  = i_valid_q;
    assign d_valid  = d_valid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_we     = we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            winner_q  <= REQ_I;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_I;
`endif
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        winner_q <= winner_d;
                        cnt_q    <= LAT_LOAD;
                        state_q  <= ST_ACCESS;
                        if (winner_d == REQ_D) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            we_q    <= d_we;
                        end else begin
                            addr_q  <= i_addr;
                            wdata_q <= '0;
                            we_q    <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= winner_d;
`endif
                    end
                end
                ST_ACCESS: begin
                    // Write strobes only in the first access cycle.
                    we_q <= '0;
                    if (cnt_q == '0) begin
                        if (winner_q == REQ_D) begin
                            d_rdata_q <= m_rdata;
                            d_valid_q <= 1'b1;
                        end else begin
                            i_rdata_q <= m_rdata;
                            i_valid_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MEM_LAT=1 instance driven from a vector table,
// and a MEM_LAT=3 instance for store-latency and mid-access reset sequences.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT = 1 instance
    logic        rst_1;
    logic        i_req_1, i_gnt_1, i_valid_1;
    logic [31:0] i_addr_1, i_rdata_1;
    logic        d_req_1, d_gnt_1, d_valid_1;
    logic [31:0] d_addr_1, d_wdata_1, d_rdata_1;
    logic [3:0]  d_we_1, m_we_1;
    logic [31:0] m_addr_1, m_wdata_1, m_rdata_1;

    // MEM_LAT = 3 instance
    logic        rst_3;
    logic        i_req_3, i_gnt_3, i_valid_3;
    logic [31:0] i_addr_3, i_rdata_3;
    logic        d_req_3, d_gnt_3, d_valid_3;
    logic [31:0] d_addr_3, d_wdata_3, d_rdata_3;
    logic [3:0]  d_we_3, m_we_3;
    logic [31:0] m_addr_3, m_wdata_3, m_rdata_3;

    mem_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst_1),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_gnt(i_gnt_1), .i_valid(i_valid_1), .i_rdata(i_rdata_1),
        .d_req(d_req_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1), .d_we(d_we_1),
        .d_gnt(d_gnt_1), .d_valid(d_valid_1), .d_rdata(d_rdata_1),
        .m_addr(m_addr_1), .m_wdata(m_wdata_1), .m_we(m_we_1), .m_rdata(m_rdata_1)
    );

    mem_arbiter #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(rst_3),
        .i_req(i_req_3), .i_addr(i_addr_3), .i_gnt(i_gnt_3), .i_valid(i_valid_3), .i_rdata(i_rdata_3),
        .d_req(d_req_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3), .d_we(d_we_3),
        .d_gnt(d_gnt_3), .d_valid(d_valid_3), .d_rdata(d_rdata_3),
        .m_addr(m_addr_3), .m_wdata(m_wdata_3), .m_we(m_we_3), .m_rdata(m_rdata_3)
    );

    // Memory models: word k holds {A000+k, 5000+k}, except word 4 (addr 0x10).
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];

    function automatic logic [31:0] init_word(input int k);
        if (k == 4) return 32'h0050_0093;
        return {16'hA000 + 16'(k), 16'h5000 + 16'(k)};
    endfunction

    assign m_rdata_1 = mem1[m_addr_1[7:2]];
    assign m_rdata_3 = mem3[m_addr_3[7:2]];

    always @(posedge clk) begin
        if (rst_1) begin
            for (int k = 0; k < 64; k++) mem1[k] <= init_word(k);
        end else begin
            for (int b = 0; b < 4; b++)
                if (m_we_1[b]) mem1[m_addr_1[7:2]][8*b +: 8] <= m_wdata_1[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (rst_3) begin
            for (int k = 0; k < 64; k++) mem3[k] <= init_word(k);
        end else begin
            for (int b = 0; b < 4; b++)
                if (m_we_3[b]) mem3[m_addr_3[7:2]][8*b +: 8] <= m_wdata_3[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        int          i_gc;
        logic [31:0] i_exp;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_we;
        int          d_gc;
        logic [31:0] d_exp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] hold_i;
    bit          hold_known;

    // One table entry on the MEM_LAT=1 instance; requests drop as soon as valid is seen.
    task automatic run_vec(input vec_t v, input int idx);
        int gc_i, gc_d, vc_i, vc_d, n_gi, n_gd, n_vi, n_vd;
        bit pend_i, pend_d;
        logic [3:0] exp_we;
        gc_i = -1; gc_d = -1; vc_i = -1; vc_d = -1;
        n_gi = 0; n_gd = 0; n_vi = 0; n_vd = 0;
        @(negedge clk);
        if (hold_known) check($sformatf("v%0d i_rdata_hold", idx), i_rdata_1, hold_i);
        i_addr_1 = v.i_addr; d_addr_1 = v.d_addr; d_wdata_1 = v.d_wdata; d_we_1 = v.d_we;
        i_req_1 = v.i_req; d_req_1 = v.d_req;
        pend_i = v.i_req; pend_d = v.d_req;
        for (int c = 0; c < 24 && (pend_i || pend_d); c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_we = (v.d_req && c == v.d_gc + 1) ? v.d_we : 4'h0;
            check($sformatf("v%0d c%0d m_we", idx, c), 32'(m_we_1), 32'(exp_we));
            check($sformatf("v%0d c%0d gnt_excl", idx, c), 32'(i_gnt_1 & d_gnt_1), 32'd0);
            check($sformatf("v%0d c%0d valid_excl", idx, c), 32'(i_valid_1 & d_valid_1), 32'd0);
            if (v.i_req && c == v.i_gc + 1) check($sformatf("v%0d i m_addr", idx), m_addr_1, v.i_addr);
            if (v.d_req && c == v.d_gc + 1) check($sformatf("v%0d d m_addr", idx), m_addr_1, v.d_addr);
            if (i_gnt_1) begin n_gi++; gc_i = c; end
            if (d_gnt_1) begin n_gd++; gc_d = c; end
            if (i_valid_1) begin
                n_vi++; vc_i = c;
                check($sformatf("v%0d i_rdata", idx), i_rdata_1, v.i_exp);
                pend_i = 1'b0; i_req_1 = 1'b0;
            end
            if (d_valid_1) begin
                n_vd++; vc_d = c;
                if (v.d_we == 4'h0) check($sformatf("v%0d d_rdata", idx), d_rdata_1, v.d_exp);
                pend_d = 1'b0; d_req_1 = 1'b0;
            end
        end
        check($sformatf("v%0d timeout", idx), 32'(pend_i | pend_d), 32'd0);
        i_req_1 = 1'b0; d_req_1 = 1'b0;
        check($sformatf("v%0d i_gnt_count", idx), 32'(n_gi), v.i_req ? 32'd1 : 32'd0);
        check($sformatf("v%0d d_gnt_count", idx), 32'(n_gd), v.d_req ? 32'd1 : 32'd0);
        check($sformatf("v%0d i_valid_count", idx), 32'(n_vi), v.i_req ? 32'd1 : 32'd0);
        check($sformatf("v%0d d_valid_count", idx), 32'(n_vd), v.d_req ? 32'd1 : 32'd0);
        if (v.i_req) begin
            check($sformatf("v%0d i_gnt_cycle", idx), 32'(gc_i), 32'(v.i_gc));
            check($sformatf("v%0d i_valid_cycle", idx), 32'(vc_i), 32'(v.i_gc + 2));
            hold_i = v.i_exp; hold_known = 1'b1;
        end
        if (v.d_req) begin
            check($sformatf("v%0d d_gnt_cycle", idx), 32'(gc_d), 32'(v.d_gc));
            check($sformatf("v%0d d_valid_cycle", idx), 32'(vc_d), 32'(v.d_gc + 2));
        end
    endtask

    initial begin
        int ng, nv;
        logic gl [4];
        int   gcyc [4];

        vecs[0] = '{1'b1, 32'h10, 0, 32'h0050_0093, 1'b0, 32'h0, 32'h0, 4'h0, -1, 32'h0};
        vecs[1] = '{1'b1, 32'h20, 3, 32'hA008_5008, 1'b1, 32'h30, 32'h0, 4'h0, 0, 32'hA00C_500C};
        vecs[2] = '{1'b0, 32'h0, -1, 32'h0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, 32'h0};
        vecs[3] = '{1'b1, 32'h44, 0, 32'hA011_5011, 1'b0, 32'h0, 32'h0, 4'h0, -1, 32'h0};
        vecs[4] = '{1'b1, 32'h40, 3, 32'h1234_5678, 1'b1, 32'h44, 32'h0000_AB00, 4'b0010, 0, 32'h0};
        vecs[5] = '{1'b0, 32'h0, -1, 32'h0, 1'b1, 32'h44, 32'h0, 4'h0, 0, 32'hA011_AB11};
        vecs[6] = '{1'b1, 32'h0, 0, 32'hA000_5000, 1'b0, 32'h0, 32'h0, 4'h0, -1, 32'h0};
        hold_i = 32'h0; hold_known = 1'b0;

        rst_1 = 1'b1; rst_3 = 1'b1;
        i_req_1 = 0; i_addr_1 = 0; d_req_1 = 0; d_addr_1 = 0; d_wdata_1 = 0; d_we_1 = 0;
        i_req_3 = 0; i_addr_3 = 0; d_req_3 = 0; d_addr_3 = 0; d_wdata_3 = 0; d_we_3 = 0;

        // Reset state, with requests raised while reset is held.
        @(negedge clk); @(negedge clk);
        i_req_1 = 1'b1; d_req_1 = 1'b1; d_we_1 = 4'hF;
        #1;
        check("rst i_gnt", 32'(i_gnt_1), 32'd0);
        check("rst d_gnt", 32'(d_gnt_1), 32'd0);
        check("rst i_valid", 32'(i_valid_1), 32'd0);
        check("rst d_valid", 32'(d_valid_1), 32'd0);
        check("rst m_we", 32'(m_we_1), 32'd0);
        check("rst m_addr", m_addr_1, 32'd0);
        check("rst i_rdata", i_rdata_1, 32'd0);
        check("rst d_rdata", d_rdata_1, 32'd0);
        i_req_1 = 1'b0; d_req_1 = 1'b0; d_we_1 = 4'h0;
        @(negedge clk);
        rst_1 = 1'b0; rst_3 = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Both requesters held for four back-to-back accesses.
        for (int k = 0; k < 4; k++) begin gl[k] = 1'b0; gcyc[k] = -1; end
        ng = 0; nv = 0;
        @(negedge clk);
        i_addr_1 = 32'h10; d_addr_1 = 32'h30; d_we_1 = 4'h0; d_wdata_1 = 32'h0;
        i_req_1 = 1'b1; d_req_1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("hold c%0d gnt_excl", c), 32'(i_gnt_1 & d_gnt_1), 32'd0);
            if (i_gnt_1 || d_gnt_1) begin
                if (ng < 4) begin gl[ng] = d_gnt_1; gcyc[ng] = c; end
                ng++;
            end
            if (i_valid_1 || d_valid_1) nv++;
        end
        i_req_1 = 1'b0; d_req_1 = 1'b0;
        check("hold grants", 32'(ng), 32'd4);
        check("hold valids", 32'(nv), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hold grant%0d is_d", k), 32'(gl[k]), RR ? 32'((k % 2) == 0) : 32'd1);
            check($sformatf("hold grant%0d cycle", k), 32'(gcyc[k]), 32'(3 * k));
        end

        // MEM_LAT=3 byte store: one-cycle strobe, valid four cycles after grant.
        @(negedge clk);
        d_addr_3 = 32'h104; d_we_3 = 4'b0010; d_wdata_3 = 32'h0000_5A00; d_req_3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("st3 c%0d m_we", c), 32'(m_we_3), (c == 1) ? 32'h2 : 32'h0);
            check($sformatf("st3 c%0d d_gnt", c), 32'(d_gnt_3), 32'(c == 0));
            check($sformatf("st3 c%0d d_valid", c), 32'(d_valid_3), 32'(c == 4));
            if (c == 1) check("st3 m_addr", m_addr_3, 32'h104);
            if (c == 1) check("st3 m_wdata", m_wdata_3, 32'h0000_5A00);
            if (d_valid_3) d_req_3 = 1'b0;
        end
        d_req_3 = 1'b0; d_we_3 = 4'h0;

        // MEM_LAT=3 fetch.
        @(negedge clk);
        i_addr_3 = 32'h20; i_req_3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("ld3 c%0d i_gnt", c), 32'(i_gnt_3), 32'(c == 0));
            check($sformatf("ld3 c%0d i_valid", c), 32'(i_valid_3), 32'(c == 4));
            if (c == 4) check("ld3 i_rdata", i_rdata_3, 32'hA008_5008);
            if (i_valid_3) i_req_3 = 1'b0;
        end
        i_req_3 = 1'b0;

        // Reset in the second access cycle of a load.
        @(negedge clk);
        d_addr_3 = 32'h30; d_we_3 = 4'h0; d_req_3 = 1'b1;
        #1;
        check("rst3 first d_gnt", 32'(d_gnt_3), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_3 = 1'b1;
        #1;
        check("rst3 i_gnt", 32'(i_gnt_3), 32'd0);
        check("rst3 d_gnt", 32'(d_gnt_3), 32'd0);
        check("rst3 i_valid", 32'(i_valid_3), 32'd0);
        check("rst3 d_valid", 32'(d_valid_3), 32'd0);
        check("rst3 i_rdata", i_rdata_3, 32'd0);
        check("rst3 d_rdata", d_rdata_3, 32'd0);
        check("rst3 m_addr", m_addr_3, 32'd0);
        check("rst3 m_wdata", m_wdata_3, 32'd0);
        check("rst3 m_we", 32'(m_we_3), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst3 hold c%0d d_valid", c), 32'(d_valid_3), 32'd0);
        end
        @(negedge clk);
        rst_3 = 1'b0;
        #1;
        check("rst3 fresh d_gnt", 32'(d_gnt_3), 32'd1);
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst3 c%0d d_gnt", c), 32'(d_gnt_3), 32'd0);
            check($sformatf("rst3 c%0d d_valid", c), 32'(d_valid_3), 32'(c == 4));
            if (c == 4) check("rst3 d_rdata after", d_rdata_3, 32'hA00C_500C);
            if (d_valid_3) d_req_3 = 1'b0;
        end
        d_req_3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
